// File: rtl/ram_bist_pkg.sv
// Shared widths, FSM state encoding and helpers for the RAM march BIST controller.
package ram_bist_pkg;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [3:0] {
        IDLE, M0, M1_RD, M1_WR, M2_RD, M2_WR, M3, DRAIN, DONE
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction
endpackage

// File: rtl/ram_bist_ctrl_if.sv
// RAM port bundle between the BIST controller (master) and the memory under test (slave).
interface ram_bist_ctrl_if;
    import ram_bist_pkg::*;

    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_write_addr;
    logic [ADDR_W-1:0] ram_read_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    modport master (output ram_data, ram_write_addr, ram_read_addr, ram_we, input ram_q);
    modport slave  (input ram_data, ram_write_addr, ram_read_addr, ram_we, output ram_q);
endinterface

// File: rtl/ram_bist_cmp.sv
// Read-compare pipeline: delays {addr, expected} by RD_LAT cycles to meet ram_q, captures first miscompare.
module ram_bist_cmp import ram_bist_pkg::*; #(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_flush,
    input  logic              i_clear,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_exp,
    input  logic [DATA_W-1:0] i_q,
    output logic              o_mismatch,
    output logic              o_failed,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [DATA_W-1:0] o_fail_data,
    output logic [DATA_W-1:0] o_fail_exp
);
    logic [RD_LAT-1:0] r_vld;
    logic [ADDR_W-1:0] r_addr [RD_LAT];
    logic [DATA_W-1:0] r_exp  [RD_LAT];
    logic              w_mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_addr[i] <= '0;
                r_exp[i]  <= '0;
            end
        end else if (i_flush) begin
            r_vld <= '0;
        end else begin
            r_vld[0]  <= i_push;
            r_addr[0] <= i_addr;
            r_exp[0]  <= i_exp;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_addr[i] <= r_addr[i-1];
                r_exp[i]  <= r_exp[i-1];
            end
        end
    end

    assign w_mismatch = r_vld[RD_LAT-1] && (i_q != r_exp[RD_LAT-1]);
    assign o_mismatch = w_mismatch;

    // Only the first miscompare of a run is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_failed    <= 1'b0;
            o_fail_addr <= '0;
            o_fail_data <= '0;
            o_fail_exp  <= '0;
        end else if (i_clear) begin
            o_failed    <= 1'b0;
            o_fail_addr <= '0;
            o_fail_data <= '0;
            o_fail_exp  <= '0;
        end else if (w_mismatch && !o_failed) begin
            o_failed    <= 1'b1;
            o_fail_addr <= r_addr[RD_LAT-1];
            o_fail_data <= i_q;
            o_fail_exp  <= r_exp[RD_LAT-1];
        end
    end
endmodule

// File: rtl/ram_bist_ctrl.sv
// March BIST over a 64x8 RAM: M0 up w(P); M1 up r(P) w(~P); M2 down r(~P) w(P); M3 up r(P).
// RAM controls are decoded from the registered state/counter, so reset silences them at once.
module ram_bist_ctrl import ram_bist_pkg::*; #(
    parameter logic [DATA_W-1:0] PATTERN = 8'h55,
    parameter int                RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [DATA_W-1:0] o_fail_data,
    output logic [DATA_W-1:0] o_fail_exp,
    ram_bist_ctrl_if.master   bus
);
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_cnt, w_cnt_next;
    logic              w_we, w_push, w_clear, w_flush, w_mismatch, w_failed;
    logic [DATA_W-1:0] w_data, w_exp;
    logic [ADDR_W-1:0] w_waddr, w_raddr;
    logic              w_last, w_first;

    assign w_last  = (r_cnt == ADDR_LAST);
    assign w_first = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_we       = 1'b0;
        w_data     = '0;
        w_waddr    = '0;
        w_raddr    = '0;
        w_push     = 1'b0;
        w_exp      = '0;
        unique case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_next     = M0;
                    w_cnt_next = '0;
                end
            end
            M0: begin
                w_we       = 1'b1;
                w_waddr    = r_cnt;
                w_data     = PATTERN;
                w_cnt_next = r_cnt + ADDR_W'(1);
                if (w_last) w_next = M1_RD;
            end
            M1_RD: begin
                w_raddr = r_cnt;
                w_push  = 1'b1;
                w_exp   = PATTERN;
                w_next  = M1_WR;
            end
            M1_WR: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                w_data  = ~PATTERN;
                if (w_last) begin
                    w_next     = M2_RD;
                    w_cnt_next = ADDR_LAST;
                end else begin
                    w_next     = M1_RD;
                    w_cnt_next = r_cnt + ADDR_W'(1);
                end
            end
            M2_RD: begin
                w_raddr = r_cnt;
                w_push  = 1'b1;
                w_exp   = ~PATTERN;
                w_next  = M2_WR;
            end
            M2_WR: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                w_data  = PATTERN;
                if (w_first) begin
                    w_next     = M3;
                    w_cnt_next = '0;
                end else begin
                    w_next     = M2_RD;
                    w_cnt_next = r_cnt - ADDR_W'(1);
                end
            end
            M3: begin
                w_raddr    = r_cnt;
                w_push     = 1'b1;
                w_exp      = PATTERN;
                w_cnt_next = r_cnt + ADDR_W'(1);
                if (w_last) begin
                    w_next     = DRAIN;
                    w_cnt_next = ADDR_W'(RD_LAT - 1);
                end
            end
            DRAIN: begin
                if (w_first) w_next = DONE;
                else         w_cnt_next = r_cnt - ADDR_W'(1);
            end
            default: w_next = IDLE;
        endcase
        // A miscompare ends the run immediately and suppresses any write in that cycle.
        if (w_mismatch) begin
            w_next = DONE;
            w_we   = 1'b0;
        end
    end

    assign w_clear = ((r_state == IDLE) || (r_state == DONE)) && i_start;
    assign w_flush = (w_next == DONE);

    ram_bist_cmp #(.RD_LAT(RD_LAT)) u_cmp (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_flush     (w_flush),
        .i_clear     (w_clear),
        .i_addr      (w_raddr),
        .i_exp       (w_exp),
        .i_q         (bus.ram_q),
        .o_mismatch  (w_mismatch),
        .o_failed    (w_failed),
        .o_fail_addr (o_fail_addr),
        .o_fail_data (o_fail_data),
        .o_fail_exp  (o_fail_exp)
    );

    assign o_busy = is_busy(r_state);
    assign o_done = (r_state == DONE);
    assign o_pass = (r_state == DONE) && !w_failed;

    assign bus.ram_we         = w_we;
    assign bus.ram_data       = w_data;
    assign bus.ram_write_addr = w_waddr;
    assign bus.ram_read_addr  = w_raddr;
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench: two controllers (RD_LAT=1 and 3) on behavioural RAMs with injectable faults.
module tb_ram_bist_ctrl;
    import ram_bist_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start, busy, done, pass, we;
    logic [5:0] fail_addr [2];
    logic [5:0] waddr [2];
    logic [5:0] raddr [2];
    logic [7:0] fail_data [2];
    logic [7:0] fail_exp [2];
    logic [7:0] wdata [2];
    int         fault;
    int         n_chk = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    // fault: 0 none, 1 addr 0x05 bit0 SA0, 2 addr 0x3F bit7 SA1, 3 write 0x10 couples into 0x11
    function automatic logic [7:0] faulty(input logic [5:0] a, input logic [7:0] d);
        if (fault == 1 && a == 6'h05) return d & 8'hFE;
        if (fault == 2 && a == 6'h3F) return d | 8'h80;
        return d;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        ram_bist_ctrl_if bus ();
        logic [7:0] mem   [64];
        logic [7:0] qpipe [LAT];

        ram_bist_ctrl #(.PATTERN(8'h55), .RD_LAT(LAT)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .i_start     (start[g]),
            .o_busy      (busy[g]),
            .o_done      (done[g]),
            .o_pass      (pass[g]),
            .o_fail_addr (fail_addr[g]),
            .o_fail_data (fail_data[g]),
            .o_fail_exp  (fail_exp[g]),
            .bus         (bus)
        );

        always @(posedge clk) begin
            if (bus.ram_we) begin
                mem[bus.ram_write_addr] <= faulty(bus.ram_write_addr, bus.ram_data);
                if (fault == 3 && bus.ram_write_addr == 6'h10) mem[6'h11] <= bus.ram_data;
            end
            qpipe[0] <= mem[bus.ram_read_addr];
            for (int k = 1; k < LAT; k++) qpipe[k] <= qpipe[k-1];
        end

        assign bus.ram_q = qpipe[LAT-1];
        assign we[g]     = bus.ram_we;
        assign wdata[g]  = bus.ram_data;
        assign waddr[g]  = bus.ram_write_addr;
        assign raddr[g]  = bus.ram_read_addr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulses start and counts rising edges from the accepting edge until done (or abort_at).
    task automatic run_bist(input int g, input int poke_at, input int abort_at, output int cyc);
        int viol;
        viol = 0;
        cyc  = 0;
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        chk("busy_rise", 32'(busy[g]), 1);
        chk("done_clr", 32'(done[g]), 0);
        chk("fail_clr", 32'(fail_addr[g]), 0);
        while (done[g] !== 1'b1 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start[g] = (cyc == poke_at);
            if (busy[g] && done[g]) viol++;
            if (cyc == abort_at) break;
        end
        start[g] = 1'b0;
        if (abort_at < 0) chk("done_seen", 32'(done[g]), 1);
        chk("busy_done_excl", 32'(viol), 0);
    endtask

    task automatic count_we(input int g, input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (we[g]) cnt++;
        end
    endtask

    initial begin
        int cyc, cnt;
        rst   = 1'b1;
        start = '0;
        fault = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_done", 32'(done[0]), 0);
        chk("rst_pass", 32'(pass[0]), 0);
        chk("rst_faddr", 32'(fail_addr[0]), 0);
        chk("rst_fdata", 32'(fail_data[0]), 0);
        chk("rst_fexp", 32'(fail_exp[0]), 0);
        chk("rst_we", 32'(we[0]), 0);
        chk("rst_wdata", 32'(wdata[0]), 0);
        chk("rst_waddr", 32'(waddr[0]), 0);
        chk("rst_raddr", 32'(raddr[0]), 0);
        rst = 1'b0;
        @(negedge clk);

        // fault-free, with an ignored start poked during M1
        run_bist(0, 100, -1, cyc);
        chk("lat1_cycles", 32'(cyc), 385);
        chk("lat1_pass", 32'(pass[0]), 1);
        chk("lat1_busy", 32'(busy[0]), 0);
        cnt = 0;
        for (int i = 0; i < 64; i++) if (g_dut[0].mem[i] !== 8'h55) cnt++;
        chk("lat1_mem_bg", 32'(cnt), 0);
        count_we(0, 8, cnt);
        chk("done_we", 32'(cnt), 0);
        chk("done_wdata", 32'(wdata[0]), 0);
        chk("done_waddr", 32'(waddr[0]), 0);

        fault = 1;
        run_bist(0, -1, -1, cyc);
        chk("sa0_cycles", 32'(cyc), 76);
        chk("sa0_pass", 32'(pass[0]), 0);
        chk("sa0_faddr", 32'(fail_addr[0]), 32'h05);
        chk("sa0_fdata", 32'(fail_data[0]), 32'h54);
        chk("sa0_fexp", 32'(fail_exp[0]), 32'h55);

        fault = 2;
        run_bist(0, -1, -1, cyc);
        chk("sa1_cycles", 32'(cyc), 192);
        chk("sa1_faddr", 32'(fail_addr[0]), 32'h3F);
        chk("sa1_fdata", 32'(fail_data[0]), 32'hD5);
        chk("sa1_fexp", 32'(fail_exp[0]), 32'h55);
        count_we(0, 20, cnt);
        chk("sa1_no_we", 32'(cnt), 0);

        fault = 3;
        run_bist(0, -1, -1, cyc);
        chk("cpl_cycles", 32'(cyc), 100);
        chk("cpl_pass", 32'(pass[0]), 0);
        chk("cpl_faddr", 32'(fail_addr[0]), 32'h11);
        chk("cpl_fdata", 32'(fail_data[0]), 32'hAA);
        chk("cpl_fexp", 32'(fail_exp[0]), 32'h55);

        // reset in the middle of an M2 write cycle
        fault = 0;
        run_bist(0, -1, 251, cyc);
        chk("pre_abort_we", 32'(we[0]), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_done", 32'(done[0]), 0);
        chk("abort_pass", 32'(pass[0]), 0);
        chk("abort_we", 32'(we[0]), 0);
        chk("abort_wdata", 32'(wdata[0]), 0);
        chk("abort_waddr", 32'(waddr[0]), 0);
        chk("abort_raddr", 32'(raddr[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy[0] || we[0]) cnt++;
        end
        chk("no_restart", 32'(cnt), 0);
        run_bist(0, -1, -1, cyc);
        chk("rerun_cycles", 32'(cyc), 385);
        chk("rerun_pass", 32'(pass[0]), 1);

        run_bist(1, -1, -1, cyc);
        chk("lat3_cycles", 32'(cyc), 387);
        chk("lat3_pass", 32'(pass[1]), 1);
        cnt = 0;
        for (int i = 0; i < 64; i++) if (g_dut[1].mem[i] !== 8'h55) cnt++;
        chk("lat3_mem_bg", 32'(cnt), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
